// File: rtl/ib_pc_seq_if.sv
// PC sequencer control/status bundle: per-cycle op request in, registered PC and stack flags out.
// Single-cycle sampling; stall is the only backpressure and freezes the sequencer.
interface ib_pc_seq_if #(
  parameter int AWIDTH = 6
);
  logic              stall;
  logic [2:0]        op;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH-1:0] offset;
  logic [AWIDTH-1:0] addr_out;
  logic              redirect;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output stall, op, addr, offset,
    input  addr_out, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, op, addr, offset,
    output addr_out, redirect, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/ib_pc_seq.sv
// Program counter with step/branch/jump and call/return stack; one-cycle registered update, no input-to-output path.
// Backpressure: stall holds every register, including redirect and the stack.
module ib_pc_seq #(
  parameter int AWIDTH     = 6,
  parameter int STEP       = 1,
  parameter int RESET_ADDR = 0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  ib_pc_seq_if.slave pc
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [AWIDTH-1:0] STEP_V  = AWIDTH'(STEP);
  localparam logic [AWIDTH-1:0] RST_V   = AWIDTH'(RESET_ADDR);
  localparam logic [PW-1:0]     TOP_MAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0]     CNT_MAX = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  logic [AWIDTH-1:0] pc_q, pc_nxt, seq_pc;
  logic              redir_q, redir_nxt;
  logic [PW-1:0]     top_q, top_nxt, top_inc, top_dec;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic              ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic              push, pop, empty, full;
  logic [AWIDTH-1:0] ras_mem [RAS_DEPTH];

  assign seq_pc  = pc_q + STEP_V;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign top_inc = (top_q == TOP_MAX) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? TOP_MAX : top_q - PW'(1);

  always_comb begin
    pc_nxt    = seq_pc;
    redir_nxt = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_nxt   = ovf_q;
    unf_nxt   = unf_q;
    case (pc.op)
      OP_BRANCH: begin
        pc_nxt    = pc_q + pc.offset;
        redir_nxt = 1'b1;
      end
      OP_JUMP: begin
        pc_nxt    = pc.addr;
        redir_nxt = 1'b1;
      end
      OP_CALL: begin
        pc_nxt    = pc.addr;
        redir_nxt = 1'b1;
        push      = 1'b1;
        if (full) ovf_nxt = 1'b1;
      end
      OP_RET: begin
        // An empty-stack return degrades to a sequential step.
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          pc_nxt    = ras_mem[top_q];
          redir_nxt = 1'b1;
          pop       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A push on a full stack advances top onto the oldest slot, overwriting it.
  always_comb begin
    top_nxt = top_q;
    cnt_nxt = cnt_q;
    if (push) begin
      top_nxt = top_inc;
      if (!full) cnt_nxt = cnt_q + CW'(1);
    end else if (pop) begin
      top_nxt = top_dec;
      cnt_nxt = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RST_V;
      redir_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!pc.stall) begin
      pc_q    <= pc_nxt;
      redir_q <= redir_nxt;
      top_q   <= top_nxt;
      cnt_q   <= cnt_nxt;
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !pc.stall && push) ras_mem[top_inc] <= seq_pc;
  end

  assign pc.addr_out  = pc_q;
  assign pc.redirect  = redir_q;
  assign pc.ras_empty = empty;
  assign pc.ras_full  = full;
  assign pc.ras_ovf   = ovf_q;
  assign pc.ras_unf   = unf_q;

endmodule

// File: tb/tb_ib_pc_seq.sv
// Directed-vector bench for ib_pc_seq at default parameters.
module tb_ib_pc_seq;
  localparam int AW = 6;
  localparam logic [2:0] SEQ = 3'b000, BR = 3'b001, JMP = 3'b010, CAL = 3'b011, RET = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ib_pc_seq_if #(.AWIDTH(AW)) bus ();

  ib_pc_seq #(
    .AWIDTH(AW), .STEP(1), .RESET_ADDR(0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc (bus.slave)
  );

  always #5 clk = ~clk;

  // fl = {redirect, ras_empty, ras_full, ras_ovf, ras_unf}
  typedef struct {
    logic          r;
    logic          s;
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] off;
    logic [AW-1:0] pc;
    logic [4:0]    fl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic [2:0] op, input int a,
                     input int off, input int pc, input logic [4:0] fl);
    vec_t v;
    v.r = r; v.s = s; v.op = op; v.a = AW'(a); v.off = AW'(off); v.pc = AW'(pc); v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] op,
                      input logic [AW-1:0] a, input logic [AW-1:0] off);
    rst        = r;
    bus.stall  = s;
    bus.op     = op;
    bus.addr   = a;
    bus.offset = off;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [AW-1:0] pc, input logic [4:0] fl);
    logic [4:0] got;
    got = {bus.redirect, bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf};
    checks++;
    if (bus.addr_out !== pc || got !== fl) begin
      failures++;
      $display("FAIL %s: addr_out=%0d flags(rd,e,f,ovf,unf)=%b, expected addr_out=%0d flags=%b",
               nm, bus.addr_out, got, pc, fl);
    end
  endtask

  initial begin
    // Branch, jump, stall, wrap
    add(1, 0, JMP, 10, 0, 10, 5'b11000);
    add(1, 0, BR,  0, 6'b111101, 7, 5'b11000);
    add(1, 0, JMP, 62, 0, 62, 5'b11000);
    add(1, 0, BR,  0, 5, 3, 5'b11000);
    add(1, 0, JMP, 1, 0, 1, 5'b11000);
    add(1, 0, BR,  0, 6'b111101, 62, 5'b11000);
    add(1, 0, JMP, 40, 0, 40, 5'b11000);
    add(1, 1, JMP, 5, 0, 40, 5'b11000);
    add(1, 1, JMP, 5, 0, 40, 5'b11000);
    add(1, 1, JMP, 5, 0, 40, 5'b11000);
    add(1, 0, BR,  0, 0, 40, 5'b11000);
    add(1, 0, SEQ, 0, 0, 41, 5'b01000);
    add(1, 1, JMP, 7, 0, 41, 5'b01000);
    add(1, 0, 3'b111, 7, 0, 42, 5'b01000);
    // Nested call/return
    add(1, 0, JMP, 5, 0, 5, 5'b11000);
    add(1, 0, CAL, 20, 0, 20, 5'b10000);
    add(1, 0, CAL, 30, 0, 30, 5'b10000);
    add(1, 0, RET, 0, 0, 21, 5'b10000);
    add(1, 0, RET, 0, 0, 6, 5'b11000);
    // Overflow, with a stalled call on the full stack
    add(1, 0, JMP, 0, 0, 0, 5'b11000);
    add(1, 0, CAL, 8, 0, 8, 5'b10000);
    add(1, 0, CAL, 8, 0, 8, 5'b10000);
    add(1, 0, CAL, 8, 0, 8, 5'b10000);
    add(1, 0, CAL, 8, 0, 8, 5'b10100);
    add(1, 1, CAL, 50, 0, 8, 5'b10100);
    add(1, 0, CAL, 8, 0, 8, 5'b10110);
    add(1, 0, RET, 0, 0, 9, 5'b10010);
    add(1, 0, RET, 0, 0, 9, 5'b10010);
    add(1, 0, RET, 0, 0, 9, 5'b10010);
    add(1, 0, RET, 0, 0, 9, 5'b11010);
    add(1, 0, RET, 0, 0, 10, 5'b01011);
    // Underflow and reset recovery
    add(0, 0, SEQ, 0, 0, 0, 5'b01000);
    add(1, 0, JMP, 12, 0, 12, 5'b11000);
    add(1, 0, RET, 0, 0, 13, 5'b01001);
    add(1, 0, SEQ, 0, 0, 14, 5'b01001);
    add(1, 0, SEQ, 0, 0, 15, 5'b01001);
    add(1, 0, CAL, 33, 0, 33, 5'b10001);
    add(0, 0, CAL, 50, 0, 0, 5'b01000);
    add(1, 0, RET, 0, 0, 1, 5'b01001);
    add(1, 0, CAL, 20, 0, 20, 5'b10001);
    add(0, 1, JMP, 9, 0, 0, 5'b01000);
    add(1, 0, SEQ, 0, 0, 1, 5'b01000);

    // Reset held two cycles, then 65 sequential steps through the wrap
    for (int i = 0; i < 2; i++) begin
      step(0, 0, SEQ, '0, '0);
      check($sformatf("reset%0d", i), '0, 5'b01000);
    end
    for (int i = 0; i < 65; i++) begin
      step(1, 0, SEQ, '0, '0);
      check($sformatf("seq%0d", i), AW'((i + 1) % 64), 5'b01000);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].off);
      check($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fl);
    end

    // Back-to-back call/return every cycle
    step(1, 0, JMP, 6'd16, '0);
    step(1, 0, CAL, 6'd48, '0);
    check("b2b_call", 6'd48, 5'b10000);
    step(1, 0, RET, '0, '0);
    check("b2b_ret", 6'd17, 5'b11000);
    step(1, 0, CAL, 6'd2, '0);
    step(1, 0, CAL, 6'd4, '0);
    step(1, 0, RET, '0, '0);
    check("b2b_ret2", 6'd3, 5'b10000);
    step(1, 0, RET, '0, '0);
    check("b2b_ret3", 6'd18, 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
